dbg_jtag_sysclk_cmd_bridge: RTL and testbench

System-clock side of a virtual-JTAG debug channel, generalised in IR width, data-register width and channel count. It performs these steps:
- Synchronises update-DR and update-IR toggle events arriving from the TCK domain.
- Captures the shifted data register into jdo.
- Decodes the instruction into one-hot take_action / take_no_action pulses per channel.
- Adds a held cmd_valid/cmd_ready handshake with sticky overrun detection.

It sits between the TCK-domain shift logic and the on-chip debug, memory and trace controllers.

---
 rtl/dbg_jtag_pkg.sv | 23 ++
 rtl/dbg_toggle_sync.sv | 28 ++
 rtl/dbg_jtag_sysclk_cmd_bridge.sv | 124 ++++++++++++
 tb/tb_dbg_jtag_sysclk_cmd_bridge.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_jtag_pkg.sv
// Shared defaults and helpers for the system-clock side of the virtual-JTAG bridge.
package dbg_jtag_pkg;

    localparam int IR_WIDTH_DEF    = 2;
    localparam int DR_WIDTH_DEF    = 38;
    localparam int ACTION_BIT_DEF  = 35;
    localparam int SYNC_STAGES_DEF = 2;

    // Widest instruction the decode helper supports; channel count follows from it.
    localparam int IR_MAX = 4;
    localparam int CH_MAX = 2**IR_MAX;

    typedef logic [IR_MAX-1:0] ir_ext_t;
    typedef logic [CH_MAX-1:0] ch_vec_t;

    function automatic ch_vec_t onehot(input ir_ext_t ir);
        ch_vec_t v;
        v     = '0;
        v[ir] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dbg_toggle_sync.sv
// Multi-flop synchroniser for a TCK-domain level; evt flags each change of the synchronised level.
module dbg_toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic evt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q   = sync_q[SYNC_STAGES-1];
    assign evt = q ^ prev_q;

endmodule

// File: rtl/dbg_jtag_sysclk_cmd_bridge.sv
// System-clock side of the virtual-JTAG channel: captures update-DR commands, decodes the
// instruction into per-channel action pulses and holds the command until the consumer accepts it.
module dbg_jtag_sysclk_cmd_bridge
    import dbg_jtag_pkg::*;
#(
    parameter int                          IR_WIDTH    = IR_WIDTH_DEF,
    parameter int                          DR_WIDTH    = DR_WIDTH_DEF,
    parameter int                          SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int                          ACTION_BIT  = ACTION_BIT_DEF,
    parameter logic [(2**IR_WIDTH)-1:0]    CH_ENABLE   = '1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      udr_toggle,
    input  logic                      uir_toggle,
    input  logic                      rti_level,
    input  logic [IR_WIDTH-1:0]       ir_in,
    input  logic [DR_WIDTH-1:0]       sr,
    input  logic                      cmd_ready,
    input  logic                      overrun_clr,
    output logic [DR_WIDTH-1:0]       jdo,
    output logic [IR_WIDTH-1:0]       ir_q,
    output logic [(2**IR_WIDTH)-1:0]  take_action,
    output logic [(2**IR_WIDTH)-1:0]  take_no_action,
    output logic                      cmd_valid,
    output logic                      ir_update,
    output logic                      st_ready_test_idle,
    output logic                      overrun
);

    localparam int NUM_CH = 2**IR_WIDTH;

    logic udr_evt;
    logic uir_evt;
    logic udr_lvl_unused;
    logic uir_lvl_unused;
    logic rti_evt_unused;

    dbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (udr_toggle),
        .q       (udr_lvl_unused),
        .evt     (udr_evt)
    );

    dbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (uir_toggle),
        .q       (uir_lvl_unused),
        .evt     (uir_evt)
    );

    dbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rti_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rti_level),
        .q       (st_ready_test_idle),
        .evt     (rti_evt_unused)
    );

    ir_ext_t           ir_ext;
    logic [NUM_CH-1:0] ch_onehot;
    logic              ch_en;
    logic              accept_ok;
    logic              dr_load;
    logic              cmd_take;
    logic              cmd_drop;

    always_comb begin
        ir_ext                 = '0;
        ir_ext[IR_WIDTH-1:0]   = ir_in;
    end

    assign ch_onehot = NUM_CH'(onehot(ir_ext));
    assign ch_en     = CH_ENABLE[ir_in];
    assign accept_ok = !cmd_valid || cmd_ready;

    // A disabled channel still refreshes jdo/ir_q but never raises valid, pulses or overrun.
    assign dr_load  = udr_evt && (!ch_en || accept_ok);
    assign cmd_take = udr_evt && ch_en && accept_ok;
    assign cmd_drop = udr_evt && ch_en && !accept_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jdo            <= '0;
            ir_q           <= '0;
            take_action    <= '0;
            take_no_action <= '0;
            cmd_valid      <= 1'b0;
            ir_update      <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            ir_update      <= uir_evt;
            take_action    <= '0;
            take_no_action <= '0;

            if (dr_load) begin
                jdo  <= sr;
                ir_q <= ir_in;
            end

            if (cmd_take) begin
                cmd_valid <= 1'b1;
                if (sr[ACTION_BIT]) begin
                    take_action <= ch_onehot;
                end else begin
                    take_no_action <= ch_onehot;
                end
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end

            // A fresh drop outranks a simultaneous clear so no loss goes unreported.
            if (cmd_drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dbg_jtag_sysclk_cmd_bridge.sv
// Directed, table-driven bench for dbg_jtag_sysclk_cmd_bridge plus hand sequences for multi-cycle cases.
module tb_dbg_jtag_sysclk_cmd_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        udr_toggle;
    logic        uir_toggle;
    logic        rti_level;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        cmd_ready;
    logic        overrun_clr;

    logic [37:0] jdo,   e_jdo;
    logic [1:0]  ir_q,  e_ir_q;
    logic [3:0]  ta,    e_ta;
    logic [3:0]  tna,   e_tna;
    logic        vld,   e_vld;
    logic        iru,   e_iru;
    logic        rti,   e_rti;
    logic        ovr,   e_ovr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dbg_jtag_sysclk_cmd_bridge dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .udr_toggle         (udr_toggle),
        .uir_toggle         (uir_toggle),
        .rti_level          (rti_level),
        .ir_in              (ir_in),
        .sr                 (sr),
        .cmd_ready          (cmd_ready),
        .overrun_clr        (overrun_clr),
        .jdo                (jdo),
        .ir_q               (ir_q),
        .take_action        (ta),
        .take_no_action     (tna),
        .cmd_valid          (vld),
        .ir_update          (iru),
        .st_ready_test_idle (rti),
        .overrun            (ovr)
    );

    dbg_jtag_sysclk_cmd_bridge #(.CH_ENABLE(4'b1011)) dut_en (
        .clk                (clk),
        .reset_n            (reset_n),
        .udr_toggle         (udr_toggle),
        .uir_toggle         (uir_toggle),
        .rti_level          (rti_level),
        .ir_in              (ir_in),
        .sr                 (sr),
        .cmd_ready          (cmd_ready),
        .overrun_clr        (overrun_clr),
        .jdo                (e_jdo),
        .ir_q               (e_ir_q),
        .take_action        (e_ta),
        .take_no_action     (e_tna),
        .cmd_valid          (e_vld),
        .ir_update          (e_iru),
        .st_ready_test_idle (e_rti),
        .overrun            (e_ovr)
    );

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] sr;
        logic        rdy;
        logic        clr;
        logic        clr_after;
        logic        consume_after;
        logic [37:0] jdo;
        logic [1:0]  irq;
        logic [3:0]  ta;
        logic [3:0]  tna;
        logic        vld;
        logic        ovr;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n     = 1'b0;
        udr_toggle  = 1'b0;
        uir_toggle  = 1'b0;
        rti_level   = 1'b0;
        ir_in       = '0;
        sr          = '0;
        cmd_ready   = 1'b0;
        overrun_clr = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Flip udr_toggle, then present rdy/clr for the edge that processes the event; ends just after it.
    task automatic send_udr(input logic [1:0] ir, input logic [37:0] s, input logic rdy, input logic clr);
        @(negedge clk);
        ir_in      = ir;
        sr         = s;
        udr_toggle = ~udr_toggle;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        cmd_ready   = rdy;
        overrun_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic end_evt();
        @(negedge clk);
        cmd_ready   = 1'b0;
        overrun_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        udr_toggle  = 1'b0;
        uir_toggle  = 1'b0;
        rti_level   = 1'b0;
        ir_in       = '0;
        sr          = '0;
        cmd_ready   = 1'b0;
        overrun_clr = 1'b0;

        //            ir    sr                rdy   clr   clra  cons  jdo               irq   ta       tna      vld   ovr
        vecs[0] = '{2'd2, 38'h08_0000_1234, 1'b0, 1'b0, 1'b0, 1'b0, 38'h08_0000_1234, 2'd2, 4'b0100, 4'b0000, 1'b1, 1'b0};
        vecs[1] = '{2'd1, 38'h00_0000_5678, 1'b0, 1'b0, 1'b1, 1'b0, 38'h08_0000_1234, 2'd2, 4'b0000, 4'b0000, 1'b1, 1'b1};
        vecs[2] = '{2'd1, 38'h00_0000_00AB, 1'b1, 1'b0, 1'b0, 1'b0, 38'h00_0000_00AB, 2'd1, 4'b0000, 4'b0010, 1'b1, 1'b0};
        vecs[3] = '{2'd3, 38'h3F_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 38'h3F_FFFF_FFFF, 2'd3, 4'b1000, 4'b0000, 1'b1, 1'b0};
        vecs[4] = '{2'd0, 38'h08_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 38'h3F_FFFF_FFFF, 2'd3, 4'b0000, 4'b0000, 1'b1, 1'b1};
        vecs[5] = '{2'd0, 38'h08_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 38'h08_0000_0000, 2'd0, 4'b0001, 4'b0000, 1'b1, 1'b1};
        vecs[6] = '{2'd3, 38'h00_0000_0001, 1'b1, 1'b0, 1'b0, 1'b0, 38'h00_0000_0001, 2'd3, 4'b0000, 4'b1000, 1'b1, 1'b1};

        // Reset state
        do_reset();
        @(posedge clk); #1;
        check("rst.jdo", jdo, 0);
        check("rst.ir_q", ir_q, 0);
        check("rst.take", {ta, tna}, 0);
        check("rst.vld_ovr_iru_rti", {vld, ovr, iru, rti}, 0);
        check("rst.en.jdo_vld", {e_jdo, e_vld}, 0);

        // Main vector table
        for (int i = 0; i < 7; i++) begin
            send_udr(vecs[i].ir, vecs[i].sr, vecs[i].rdy, vecs[i].clr);
            check($sformatf("v%0d.jdo", i), jdo, vecs[i].jdo);
            check($sformatf("v%0d.ir_q", i), ir_q, vecs[i].irq);
            check($sformatf("v%0d.take_action", i), ta, vecs[i].ta);
            check($sformatf("v%0d.take_no_action", i), tna, vecs[i].tna);
            check($sformatf("v%0d.cmd_valid", i), vld, vecs[i].vld);
            check($sformatf("v%0d.overrun", i), ovr, vecs[i].ovr);
            end_evt();
            @(posedge clk); #1;
            check($sformatf("v%0d.pulse_width", i), {ta, tna}, 0);
            if (vecs[i].clr_after) begin
                @(negedge clk); overrun_clr = 1'b1;
                @(posedge clk); #1;
                check($sformatf("v%0d.overrun_clr", i), ovr, 0);
                @(negedge clk); overrun_clr = 1'b0;
            end
            if (vecs[i].consume_after) begin
                @(negedge clk); cmd_ready = 1'b1;
                @(posedge clk); #1;
                check($sformatf("v%0d.consume", i), vld, 0);
                @(negedge clk); cmd_ready = 1'b0;
            end
        end

        // Disabled channel 2 on the masked instance
        do_reset();
        send_udr(2'd2, 38'h08_0000_1234, 1'b0, 1'b0);
        check("dis.jdo", e_jdo, 38'h08_0000_1234);
        check("dis.ir_q", e_ir_q, 2);
        check("dis.take", {e_ta, e_tna}, 0);
        check("dis.cmd_valid", e_vld, 0);
        end_evt();
        send_udr(2'd3, 38'h08_0000_0001, 1'b0, 1'b0);
        check("dis.ch3_take", e_ta, 4'b1000);
        check("dis.ch3_valid", e_vld, 1);
        end_evt();
        send_udr(2'd2, 38'h00_0000_0077, 1'b0, 1'b0);
        check("dis.held_jdo", e_jdo, 38'h00_0000_0077);
        check("dis.held_take", {e_ta, e_tna}, 0);
        check("dis.held_valid_ovr", {e_vld, e_ovr}, 2'b10);
        end_evt();

        // Simultaneous uir and udr events
        do_reset();
        @(negedge clk);
        ir_in      = 2'd2;
        sr         = 38'h08_0000_1234;
        udr_toggle = 1'b1;
        uir_toggle = 1'b1;
        @(posedge clk); #1;
        check("sim.E0_quiet", {iru, ta}, 0);
        @(posedge clk);
        @(posedge clk); #1;
        check("sim.ir_update", iru, 1);
        check("sim.take_action", ta, 4'b0100);
        @(posedge clk); #1;
        check("sim.pulses_end", {iru, ta}, 0);
        @(negedge clk);
        ir_in      = 2'd1;
        uir_toggle = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("uir.ir_update", iru, 1);
        check("uir.ir_q_kept", ir_q, 2);

        // rti_level synchroniser latency
        @(negedge clk); rti_level = 1'b1;
        @(posedge clk); #1;
        check("rti.E0", rti, 0);
        @(posedge clk); #1;
        check("rti.E1", rti, 1);

        // Reset while a command is in flight
        do_reset();
        send_udr(2'd1, 38'h08_0000_0042, 1'b0, 1'b0);
        check("rstmid.setup", ta, 4'b0010);
        end_evt();
        @(negedge clk); cmd_ready = 1'b1;
        @(negedge clk); cmd_ready = 1'b0;
        udr_toggle = 1'b0;
        @(posedge clk);
        @(negedge clk); reset_n = 1'b0;
        #1;
        check("rstmid.jdo", jdo, 0);
        check("rstmid.ir_q", ir_q, 0);
        check("rstmid.flags", {ta, tna, vld, ovr, iru}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check($sformatf("rstmid.after%0d", c), {ta, tna, vld}, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
